// File: rtl/fq_sweep_ctrl.sv
// fq_sweep_ctrl: steps the fq divider setting from a first value by a fixed
// increment up to a last value, dwelling at each setting for a programmed
// number of clk_out rising edges. Host sees a start/stop/busy/done handshake.
module fq_sweep_ctrl #(
  parameter int DIV_W   = 8,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DIV_W-1:0]   div_first,
  input  logic [DIV_W-1:0]   div_step,
  input  logic [DIV_W-1:0]   div_last,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               fq_clk,
  output logic [DIV_W-1:0]   cnt_out,
  output logic               busy,
  output logic               step_pulse,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DWELL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q,    state_d;
  logic [DIV_W-1:0]   set_q,      set_d;       // current divider setting
  logic [DIV_W-1:0]   step_q,     step_d;      // shadow of div_step
  logic [DIV_W-1:0]   last_q,     last_d;      // shadow of div_last
  logic [DWELL_W-1:0] dwell_q,    dwell_d;     // shadow of dwell
  logic [DWELL_W-1:0] edge_cnt_q, edge_cnt_d;  // clk_out edges seen at this setting
  logic               fq_hist_q,  fq_hist_d;   // fq_clk one cycle ago
  logic [DIV_W-1:0]   cnt_out_q,  cnt_out_d;
  logic               busy_q,     busy_d;
  logic               pulse_q,    pulse_d;
  logic               done_q,     done_d;

  // Helpers: effective dwell, edge detect, next setting with carry.
  logic [DWELL_W-1:0] dwell_eff;
  logic [DWELL_W:0]   edge_inc;
  logic               fq_rise;
  logic               dwell_hit;
  logic [DIV_W:0]     nxt_set;
  logic               sweep_end;

  // Datapath helpers; the wide adds keep carries visible instead of wrapping.
  always_comb begin
    dwell_eff = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
    fq_rise   = fq_clk & ~fq_hist_q;
    edge_inc  = {1'b0, edge_cnt_q} + {{DWELL_W{1'b0}}, 1'b1};
    dwell_hit = fq_rise && (edge_inc == {1'b0, dwell_eff});
    nxt_set   = {1'b0, set_q} + {1'b0, step_q};
    // A zero step would repeat the same setting forever, so it ends the sweep.
    sweep_end = (step_q == '0) || nxt_set[DIV_W] || (nxt_set > {1'b0, last_q});
  end

  // Next-state and next-output logic; stop overrides everything outside IDLE.
  always_comb begin
    state_d    = state_q;
    set_d      = set_q;
    step_d     = step_q;
    last_d     = last_q;
    dwell_d    = dwell_q;
    edge_cnt_d = edge_cnt_q;
    fq_hist_d  = fq_clk;
    cnt_out_d  = cnt_out_q;
    busy_d     = busy_q;
    pulse_d    = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_out_d = '0;
        busy_d    = 1'b0;
        if (start && !stop) begin
          set_d     = div_first;
          step_d    = div_step;
          last_d    = div_last;
          dwell_d   = dwell;
          cnt_out_d = div_first;
          busy_d    = 1'b1;
          pulse_d   = 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        // History reloads from fq_clk here too, so a level already high on
        // entry to DWELL is not mistaken for a fresh edge.
        edge_cnt_d = '0;
        state_d    = S_DWELL;
      end
      S_DWELL: begin
        if (fq_rise) begin
          edge_cnt_d = edge_inc[DWELL_W-1:0];
        end
        if (dwell_hit) begin
          if (sweep_end) begin
            cnt_out_d = '0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = S_DONE;
          end else begin
            set_d     = nxt_set[DIV_W-1:0];
            cnt_out_d = nxt_set[DIV_W-1:0];
            pulse_d   = 1'b1;
            state_d   = S_LOAD;
          end
        end
      end
      S_DONE: begin
        cnt_out_d = '0;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (stop && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      cnt_out_d = '0;
      busy_d    = 1'b0;
      pulse_d   = 1'b0;
      done_d    = 1'b0;
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      set_q      <= '0;
      step_q     <= '0;
      last_q     <= '0;
      dwell_q    <= '0;
      edge_cnt_q <= '0;
      fq_hist_q  <= 1'b0;
      cnt_out_q  <= '0;
      busy_q     <= 1'b0;
      pulse_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      set_q      <= set_d;
      step_q     <= step_d;
      last_q     <= last_d;
      dwell_q    <= dwell_d;
      edge_cnt_q <= edge_cnt_d;
      fq_hist_q  <= fq_hist_d;
      cnt_out_q  <= cnt_out_d;
      busy_q     <= busy_d;
      pulse_q    <= pulse_d;
      done_q     <= done_d;
    end
  end

  assign cnt_out    = cnt_out_q;
  assign busy       = busy_q;
  assign step_pulse = pulse_q;
  assign done       = done_q;

endmodule

// File: doc/fq_sweep_ctrl.md
Name: fq_sweep_ctrl

Overview:
- Sequencer for the fq programmable clock divider: drives its 8-bit cnt_in and steps it through a programmed sweep (start, step, end).
- Dwells at each divider setting for a programmed number of rising edges of the divider's clk_out.
- Sits between the host/config logic and fq; used for transducer frequency sweeps in the ranging front end.
- Start/stop/busy/done handshake toward the host.

Parameters:
- DIV_W, 8, width of the divider setting (matches fq cnt_in).
- DWELL_W, 16, width of the dwell counter (clk_out rising edges per step).

Ports:
- clk  in  1  system clock; same clock that drives fq.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- stop  in  1  synchronous abort; honoured in any state.
- div_first  in  DIV_W  first divider setting.
- div_step  in  DIV_W  increment between settings.
- div_last  in  DIV_W  last permitted setting (inclusive).
- dwell  in  DWELL_W  clk_out rising edges per setting; 0 is treated as 1.
- fq_clk  in  1  clk_out of fq (synchronous to clk; no synchroniser).
- cnt_out  out  DIV_W  to fq cnt_in.
- busy  out  1  high while a sweep is active.
- step_pulse  out  1  one-cycle pulse each time cnt_out takes a new value during a sweep.
- done  out  1  one-cycle pulse on normal sweep completion.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, cnt_out=0, busy=0, step_pulse=0, done=0, edge counter=0, fq_clk history register=0. Reset mid-sweep aborts immediately with no done pulse.
- States: IDLE, LOAD, DWELL, DONE.
- IDLE:
  - cnt_out=0, busy=0.
  - start=1 and stop=0 → latch div_first/div_step/div_last/dwell into shadow registers; go to LOAD.
  - Config inputs are ignored after the latch.
- LOAD (one cycle):
  - cnt_out=current setting; busy=1; step_pulse=1.
  - Edge counter cleared; fq_clk history register loaded with the current fq_clk, so no edge is counted in LOAD.
  - Go to DWELL.
  - Latency: start sampled at edge N → cnt_out=div_first, busy=1, step_pulse=1 during cycle N+1.
- DWELL:
  - Rising edge = fq_clk & ~fq_clk_q. Each rising edge increments the edge counter.
  - On the edge that makes the count equal the effective dwell (max(dwell,1)), compute next = setting + div_step in DIV_W+1 bits.
  - If div_step=0, or next carries out, or next > div_last → go to DONE.
  - Otherwise setting=next[DIV_W-1:0]; go to LOAD.
- DONE (one cycle): done=1, busy=0, cnt_out=0; go to IDLE.
- div_first > div_last: div_first is still applied for one full dwell, then DONE (single step).
- stop=1 in any non-IDLE state → next cycle IDLE, cnt_out=0, busy=0, no done pulse. stop has priority over all other events, including a start in the same cycle.
- start while busy: ignored, no effect on the running sweep.
- Counter saturation is not possible: the count compares against the latched dwell and is cleared in LOAD.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
1. Reset held 5 cycles, then released → cnt_out=0, busy=0, done=0; cycles with fq_clk toggling cause no change.
2. div_first=1, div_step=1, div_last=4, dwell=2, driving a real fq instance → cnt_out sequence 1,2,3,4, each held for exactly 2 clk_out rising edges; 4 step_pulses total; done pulses once, 1 cycle after the 2nd edge at setting 4; busy low in the same cycle as done.
3. div_first=250, div_step=10, div_last=255 → setting 250 for one dwell; 260 carries out → done; cnt_out never takes 4 (no wrap).
4. dwell=0, div_first=2, div_step=2, div_last=6 → cnt_out 2,4,6, each for exactly 1 edge; then done.
5. Start a sweep 1..8, assert stop during setting 3 → cnt_out=0 and busy=0 next cycle; no done; a new start is accepted on the following cycle.
6. Pulse start again mid-sweep, then assert rst mid-sweep → the second start has no effect on the sequence; rst returns all outputs to reset values on the next edge with no done pulse.
